// File: rtl/link_bringup_pkg.sv
// Shared definitions for the transceiver lane bring-up sequencer:
// state encodings and the cycle-counter width helper.
package link_bringup_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RESET_PCS  = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd2;
  localparam logic [2:0] ST_WAIT_ALIGN = 3'd3;
  localparam logic [2:0] ST_STABLE     = 3'd4;
  localparam logic [2:0] ST_RUN        = 3'd5;
  localparam logic [2:0] ST_RETRY      = 3'd6;
  localparam logic [2:0] ST_FAIL       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_RESET_PCS  = ST_RESET_PCS,
    S_WAIT_LOCK  = ST_WAIT_LOCK,
    S_WAIT_ALIGN = ST_WAIT_ALIGN,
    S_STABLE     = ST_STABLE,
    S_RUN        = ST_RUN,
    S_RETRY      = ST_RETRY,
    S_FAIL       = ST_FAIL
  } state_e;

  // One extra bit keeps the saturating counter clear of its largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous status bit into the SYSCLK domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_bringup_seq.sv
// Bring-up sequencer for one transceiver lane: PCS reset, lock/align wait,
// stability window, then PRBS release, with timeout and bounded retry.
//
// state      | meaning
// IDLE       | start_req low, everything held off
// RESET_PCS  | pcs_rst_n low for RST_CYCLES
// WAIT_LOCK  | waiting for PLL lock, CDR lock and lane ready
// WAIT_ALIGN | lock held, waiting for comma alignment
// STABLE     | all status must stay high for STABLE_CYCLES
// RUN        | PRBS running, link up
// RETRY      | one-cycle decision: another attempt or give up
// FAIL       | retries exhausted, PCS held in reset
module link_bringup_seq
  import link_bringup_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 256,
  parameter int MAX_RETRY      = 3
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       start_req,
  input  logic       tx_pll_lock,
  input  logic       rx_cdr_lock,
  input  logic       lane_ready,
  input  logic       rx_align,
  output logic       pcs_rst_n,
  output logic       prbs_start,
  output logic       link_up,
  output logic       link_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam int CW = cnt_width(RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  logic [3:0] status_raw;
  logic [3:0] status_sync;
  logic       lock_ok;
  logic       all_ok;

  state_e        state_q, state_nxt;
  logic [CW-1:0] cnt_q;
  logic [1:0]    retry_q;

  assign status_raw = {rx_align, lane_ready, rx_cdr_lock, tx_pll_lock};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync_2ff u_sync (
      .clk   (SYSCLK),
      .rst_n (NSYSRESET),
      .d     (status_raw[i]),
      .q     (status_sync[i])
    );
  end

  assign lock_ok = &status_sync[2:0];
  assign all_ok  = &status_sync;

  always_comb begin
    state_nxt = state_q;
    if (!start_req) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       state_nxt = S_RESET_PCS;
        S_RESET_PCS:  if (cnt_q == RST_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_ok)               state_nxt = S_WAIT_ALIGN;
          else if (cnt_q == TO_LAST) state_nxt = S_RETRY;
        end
        S_WAIT_ALIGN: begin
          if (all_ok)                state_nxt = S_STABLE;
          else if (!lock_ok)         state_nxt = S_RETRY;
          else if (cnt_q == TO_LAST) state_nxt = S_RETRY;
        end
        S_STABLE: begin
          if (!all_ok)                state_nxt = S_RETRY;
          else if (cnt_q == STB_LAST) state_nxt = S_RUN;
        end
        S_RUN:        if (!all_ok) state_nxt = S_RETRY;
        S_RETRY:      state_nxt = (retry_q == RETRY_MAX) ? S_FAIL : S_RESET_PCS;
        S_FAIL:       state_nxt = S_FAIL;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode from state_nxt so they move on the same edge as the state.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= 2'd0;
      pcs_rst_n  <= 1'b0;
      prbs_start <= 1'b0;
      link_up    <= 1'b0;
      link_fail  <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (state_nxt != state_q || state_nxt == S_IDLE) cnt_q <= '0;
      else if (cnt_q != CNT_MAX)                       cnt_q <= cnt_q + CW'(1);

      if (state_nxt == S_IDLE)
        retry_q <= 2'd0;
      else if (state_q == S_RETRY && state_nxt == S_RESET_PCS && retry_q != RETRY_MAX)
        retry_q <= retry_q + 2'd1;

      pcs_rst_n  <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_WAIT_ALIGN) ||
                    (state_nxt == S_STABLE)    || (state_nxt == S_RUN) ||
                    (state_nxt == S_RETRY);
      prbs_start <= (state_nxt == S_RUN);
      link_up    <= (state_nxt == S_RUN);
      link_fail  <= (state_nxt == S_FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_link_bringup_seq.sv
// Directed bench for link_bringup_seq: expectations are queued with the edge
// they are due on and compared on the following falling edge.
module tb_link_bringup_seq;

  logic       SYSCLK = 1'b0;
  logic       NSYSRESET;
  logic       start_req;
  logic       tx_pll_lock, rx_cdr_lock, lane_ready, rx_align;
  logic       pcs_rst_n, prbs_start, link_up, link_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  link_bringup_seq #(
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (64),
    .STABLE_CYCLES  (8),
    .MAX_RETRY      (2)
  ) dut (
    .SYSCLK      (SYSCLK),
    .NSYSRESET   (NSYSRESET),
    .start_req   (start_req),
    .tx_pll_lock (tx_pll_lock),
    .rx_cdr_lock (rx_cdr_lock),
    .lane_ready  (lane_ready),
    .rx_align    (rx_align),
    .pcs_rst_n   (pcs_rst_n),
    .prbs_start  (prbs_start),
    .link_up     (link_up),
    .link_fail   (link_fail),
    .retry_cnt   (retry_cnt),
    .state_o     (state_o)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    int         edge_no;
    string      tag;
    logic [8:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int edge_n  = 0;
  int n_check = 0;
  int n_fail  = 0;

  always @(posedge SYSCLK) edge_n <= edge_n + 1;

  // Reference output decode: {pcs_rst_n, prbs_start, link_up, link_fail, retry_cnt, state}
  function automatic logic [8:0] model(input int st, input int rc);
    logic pcs, run, fl;
    logic [1:0] r;
    logic [2:0] s;
    pcs = (st >= 2 && st <= 6);
    run = (st == 5);
    fl  = (st == 7);
    r   = rc[1:0];
    s   = st[2:0];
    return {pcs, run, run, fl, r, s};
  endfunction

  task automatic expect_at(input int k, input string tag, input int st, input int rc);
    sb_entry_t e;
    e.edge_no = edge_n + k;
    e.tag     = tag;
    e.exp     = model(st, rc);
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  always @(negedge SYSCLK) begin
    sb_entry_t e;
    logic [8:0] obs;
    while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
      e   = sb.pop_front();
      obs = {pcs_rst_n, prbs_start, link_up, link_fail, retry_cnt, state_o};
      n_check++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s @edge %0d: observed %b expected %b", e.tag, edge_n, obs, e.exp);
      end
    end
  end

  initial begin
    NSYSRESET   = 1'b0;
    start_req   = 1'b0;
    tx_pll_lock = 1'b1;
    rx_cdr_lock = 1'b1;
    lane_ready  = 1'b1;
    rx_align    = 1'b1;

    tick(3);
    expect_at(0, "reset_state", 0, 0);
    tick(1);
    NSYSRESET = 1'b1;
    tick(3);

    // Nominal bring-up with all status already high
    start_req = 1'b1;
    expect_at(1,  "nom_reset_entry", 1, 0);
    expect_at(4,  "nom_reset_last",  1, 0);
    expect_at(5,  "nom_wait_lock",   2, 0);
    expect_at(6,  "nom_wait_align",  3, 0);
    expect_at(7,  "nom_stable",      4, 0);
    expect_at(14, "nom_stable_last", 4, 0);
    expect_at(15, "nom_run",         5, 0);
    tick(16);

    // CDR drop in RUN: RETRY three edges later, then a fresh attempt
    rx_cdr_lock = 1'b0;
    expect_at(2, "cdr_drop_run_hold", 5, 0);
    expect_at(3, "cdr_drop_retry",    6, 0);
    expect_at(4, "cdr_drop_reset",    1, 1);
    tick(4);
    rx_cdr_lock = 1'b1;
    expect_at(4,  "cdr_relock_wait",  2, 1);
    expect_at(14, "cdr_relock_run",   5, 1);
    tick(15);
    start_req = 1'b0;
    expect_at(1, "stop_from_run", 0, 0);
    tick(2);

    // One-cycle align glitch during STABLE
    start_req = 1'b1;
    expect_at(7, "glitch_stable", 4, 0);
    tick(8);
    rx_align = 1'b0;
    tick(1);
    rx_align = 1'b1;
    expect_at(2,  "glitch_retry",       6, 0);
    expect_at(3,  "glitch_reset",       1, 1);
    expect_at(6,  "glitch_reset_last",  1, 1);
    expect_at(7,  "glitch_wait_lock",   2, 1);
    expect_at(17, "glitch_run",         5, 1);
    tick(18);
    start_req = 1'b0;
    tick(2);

    // Stop while in WAIT_ALIGN
    rx_align = 1'b0;
    tick(3);
    start_req = 1'b1;
    tick(8);
    expect_at(0, "wait_align_hold", 3, 0);
    start_req = 1'b0;
    expect_at(1, "stop_from_align", 0, 0);
    tick(2);
    rx_align = 1'b1;

    // PLL never locks: three timed-out attempts then FAIL
    tx_pll_lock = 1'b0;
    tick(3);
    start_req = 1'b1;
    expect_at(68,  "to1_last_wait", 2, 0);
    expect_at(69,  "to1_retry",     6, 0);
    expect_at(70,  "to2_reset",     1, 1);
    expect_at(138, "to2_retry",     6, 1);
    expect_at(139, "to3_reset",     1, 2);
    expect_at(207, "to3_retry",     6, 2);
    expect_at(208, "fail_entry",    7, 2);
    expect_at(211, "fail_hold",     7, 2);
    tick(212);
    start_req = 1'b0;
    expect_at(1, "stop_from_fail", 0, 0);
    tick(2);
    tx_pll_lock = 1'b1;
    tick(3);

    // Asynchronous reset mid-RUN, then restart
    start_req = 1'b1;
    expect_at(15, "pre_reset_run", 5, 0);
    tick(17);
    #2;
    NSYSRESET = 1'b0;
    expect_at(0, "async_reset_now", 0, 0);
    tick(3);
    expect_at(0, "async_reset_held", 0, 0);
    tick(1);
    NSYSRESET = 1'b1;
    expect_at(1,  "restart_reset",  1, 0);
    expect_at(5,  "restart_wait",   2, 0);
    expect_at(15, "restart_run",    5, 0);
    tick(17);

    n_check++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/link_bringup_seq.md
# link_bringup_seq

Bring-up sequencer for one PolarFire transceiver lane in the PRBS loopback test design. It holds the lane PCS in reset, then waits for TX PLL lock, CDR lock, lane ready and comma alignment. Once all four have stayed stable for a set time, it releases the PRBS pattern generator/checker via `prbs_start`. It replaces the hard-coded start timing; it sits between the UART command interface (`start_req`) and the transceiver/PRBS datapath, with timeout, bounded retry and a fail flag.

## Interface
- `RST_CYCLES`, default 16: cycles `pcs_rst_n` is held low per attempt (≥1).
- `TIMEOUT_CYCLES`, default 65536: maximum cycles allowed in WAIT_LOCK and in WAIT_ALIGN, counted separately per state (≥2).
- `STABLE_CYCLES`, default 256: consecutive cycles all status must stay high before RUN (≥1).
- `MAX_RETRY`, default 3: retries allowed after the first attempt (0..3).
- `SYSCLK`  in  1  fabric clock, 156.25 MHz.
- `NSYSRESET`  in  1  reset; asynchronous assert, active-low.
- `start_req`  in  1  level from UART interface, SYSCLK domain; 1 = run link, 0 = stop.
- `tx_pll_lock`  in  1  transceiver TX PLL lock; asynchronous.
- `rx_cdr_lock`  in  1  lane CDR lock; asynchronous.
- `lane_ready`  in  1  lane PMA/PCS ready; asynchronous.
- `rx_align`  in  1  comma/word aligned; asynchronous.
- `pcs_rst_n`  out  1  lane PCS reset, active-low.
- `prbs_start`  out  1  enable to PRBS generator/checker.
- `link_up`  out  1  high in RUN.
- `link_fail`  out  1  high in FAIL.
- `retry_cnt`  out  2  retries used in the current run.
- `state_o`  out  3  current state encoding, for debug/UART readback.

## Operation
- The four status inputs each pass through a 2-FF synchronizer. "all_ok" = AND of the synced lock, CDR, ready and align bits. "lock_ok" = same without align.
- States and encodings: IDLE=0, RESET_PCS=1, WAIT_LOCK=2, WAIT_ALIGN=3, STABLE=4, RUN=5, RETRY=6, FAIL=7.
- Global rule: `start_req`=0 in any state → IDLE on the next edge. This overrides every other transition.
- IDLE: `start_req`=1 → RESET_PCS; clear `retry_cnt` and the counter.
- RESET_PCS: `pcs_rst_n`=0. After RST_CYCLES cycles in this state → WAIT_LOCK.
- WAIT_LOCK: `pcs_rst_n`=1.
  - lock_ok → WAIT_ALIGN.
  - Otherwise, counter reaches TIMEOUT_CYCLES-1 → RETRY.
- WAIT_ALIGN: the counter restarts at 0 on entry.
  - all_ok → STABLE.
  - lock_ok drops → RETRY.
  - Timeout → RETRY, using the same rule as WAIT_LOCK.
- STABLE: all_ok must stay high for STABLE_CYCLES consecutive cycles → RUN. Any low cycle → RETRY.
- RUN: `prbs_start`=1 and `link_up`=1. all_ok low for any cycle → RETRY. There is no timeout in RUN.
- RETRY: one cycle.
  - `retry_cnt`==MAX_RETRY → FAIL.
  - Otherwise `retry_cnt`+1 → RESET_PCS.
- FAIL: `pcs_rst_n`=0 and `link_fail`=1. Remains here until `start_req`=0.
- Counter: a single unsigned counter, width $clog2(max of the three cycle parameters)+1. It is cleared on every state change and does not wrap.
- `retry_cnt` saturates at MAX_RETRY. It is cleared only in IDLE.

## Timing
- Reset values: state IDLE, `pcs_rst_n`=0, `prbs_start`=0, `link_up`=0, `link_fail`=0, `retry_cnt`=0, `state_o`=0, synchronizers 0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Status input rise → state transition: 3 edges (2 sync + 1 FSM).
- `start_req`=0 → IDLE and `prbs_start`=0: 1 edge.
- all_ok drop in RUN → `prbs_start`=0: 3 edges.
- RESET_PCS holds `pcs_rst_n` low for exactly RST_CYCLES cycles.
- From first all_ok in STABLE to entering RUN: STABLE_CYCLES cycles.
- Simultaneous events:
  - Timeout and success in the same cycle: success wins.
  - `start_req`=0 together with any other event: IDLE wins.
- Reset asserted mid-sequence: all outputs go to their reset values immediately (asynchronous). Release is synchronous to SYSCLK.

## Structure
- Package `link_bringup_pkg`: state encoding localparams (3-bit) and the counter-width function.
- Sub-module `sync_2ff`, instantiated once per status bit. It has no reset on its data path apart from NSYSRESET clearing it to 0.
- The FSM, counter and output registers live in `link_bringup_seq`.

## Test plan
All tests use `RST_CYCLES`=4, `TIMEOUT_CYCLES`=64, `STABLE_CYCLES`=8, `MAX_RETRY`=2.
1. Nominal: status already high, `start_req`↑ at t0.
   - `pcs_rst_n` low 4 cycles.
   - `prbs_start`=1 and `link_up`=1 at t0+4+1+1+8+1 edges (±sync latency as specified).
   - `retry_cnt`=0.
2. `tx_pll_lock` stuck 0 → three attempts of 4 + 64 cycles each, then `link_fail`=1, `retry_cnt`=2, `state_o`=7.
3. `rx_align` pulses low for 1 cycle during STABLE → RETRY, `retry_cnt`=1, `pcs_rst_n` low 4 cycles, then RUN.
4. In RUN, `rx_cdr_lock` drops → `prbs_start`=0 exactly 3 edges later, `state_o`=6 then 1.
5. `start_req`→0 in WAIT_ALIGN and in FAIL → next edge `state_o`=0, all outputs 0, `retry_cnt`=0.
6. `NSYSRESET` asserted mid-RUN, off-edge → outputs reach reset values before the next SYSCLK edge. Release with `start_req`=1 → normal sequence restarts from RESET_PCS.
